// File: rtl/instruction_fetch_pkg.sv
// Shared constants and state encodings for the RV32I instruction fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request (valid/ready) and response (valid-only) channels.
interface instruction_fetch_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry {instruction, pc} holding register that absorbs a response while decode stalls.
module fetch_skid_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            unload_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
    end else if (unload_i) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= '0;
      pc_q    <= '0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, keeps one request in flight and produces the IF/ID register.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                   clock,
  input  logic                   reset,
  instruction_fetch_if.master    imem,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_target,
  output logic                   IF_valid,
  output logic [XLEN-1:0]        IF_instruction,
  output logic [XLEN-1:0]        IF_pc,
  output logic                   IF_misaligned
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_q, inflight_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic            mis_q, mis_d;

  logic            req_valid;
  logic            req_fire;
  logic            deliver;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic            skid_load;
  logic            skid_unload;

  fetch_skid_buffer #(.XLEN(XLEN)) u_skid (
    .clk_i    (clock),
    .rst_i    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (redirect_valid),
    .instr_i  (imem.imem_resp_data),
    .pc_i     (inflight_q),
    .valid_o  (skid_valid),
    .instr_o  (skid_instr),
    .pc_o     (skid_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // A response arriving together with a redirect in WAIT is the one being squashed,
  // so there is nothing left to drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: if (req_fire) state_d = S_WAIT;
      S_WAIT: begin
        if (imem.imem_resp_valid)  state_d = S_FETCH;
        else if (redirect_valid)   state_d = S_DRAIN;
      end
      S_DRAIN: if (imem.imem_resp_valid) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    if (!reset && state_q == S_FETCH && !skid_valid && !redirect_valid) begin
      req_valid = 1'b1;
    end
  end

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc_q;
  assign req_fire            = req_valid && imem.imem_req_ready;
  assign deliver             = (state_q == S_WAIT) && imem.imem_resp_valid && !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    mis_d      = mis_q;
    if (redirect_valid) begin
      pc_d  = {redirect_target[XLEN-1:2], 2'b00};
      mis_d = |redirect_target[1:0];
    end else if (req_fire) begin
      inflight_d = pc_q;
      pc_d       = pc_q + XLEN'(4);
    end
  end

  always_comb begin
    if_valid_d  = if_valid_q;
    if_instr_d  = if_instr_q;
    if_pc_d     = if_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (redirect_valid) begin
      if_valid_d = 1'b0;
      if_instr_d = XLEN'(NOP_INSTR);
    end else if (!stall && skid_valid) begin
      if_valid_d  = 1'b1;
      if_instr_d  = skid_instr;
      if_pc_d     = skid_pc;
      skid_unload = 1'b1;
    end else if (deliver && (!if_valid_q || !stall)) begin
      if_valid_d = 1'b1;
      if_instr_d = imem.imem_resp_data;
      if_pc_d    = inflight_q;
    end else if (deliver) begin
      skid_load = 1'b1;
    end else if (!stall) begin
      if_valid_d = 1'b0;
      if_instr_d = XLEN'(NOP_INSTR);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= XLEN'(NOP_INSTR);
      if_pc_q    <= RESET_PC;
      mis_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      mis_q      <= mis_d;
    end
  end

  assign IF_valid       = if_valid_q;
  assign IF_instruction = if_instr_q;
  assign IF_pc          = if_pc_q;
  assign IF_misaligned  = mis_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- First stage of the RV32I 5-stage pipeline; sits directly upstream of instruction decode and produces the IF/ID pipeline register (instruction, PC, valid) that feeds control, register file and immediate generator.
- Owns the program counter. Issues word fetches to instruction memory over a valid/ready request channel with a valid-only response channel.
- Keeps at most one request outstanding. Absorbs decode stalls with a 1-entry skid buffer and squashes wrong-path fetches on branch redirect.

Parameters:
- XLEN, 32, datapath/address width (from riscv.h).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  XLEN  byte address of the word fetched (= pc).
- imem_resp_valid  input  1  response data valid; arrives at least 1 cycle after acceptance, in order.
- imem_resp_data  input  XLEN  fetched instruction word.
- stall  input  1  decode cannot accept; hold the IF/ID register.
- redirect_valid  input  1  branch taken in EX; refetch from redirect_target.
- redirect_target  input  XLEN  new PC.
- IF_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- IF_instruction  output  XLEN  IF/ID instruction; NOP_INSTR when bubble.
- IF_pc  output  XLEN  PC of IF_instruction.
- IF_misaligned  output  1  redirect_target[1:0] != 0 was taken; held until the next redirect or reset.

Behaviour:
- Reset (synchronous, held ≥1 cycle):
  - pc = RESET_PC, state = FETCH, skid empty.
  - IF_valid = 0, IF_instruction = NOP_INSTR (32'h0000_0013), IF_pc = RESET_PC, IF_misaligned = 0.
  - imem_req_valid = 0 while reset is high.
- States:
  - FETCH: imem_req_valid = !skid_valid && !redirect_valid. On handshake (valid && ready): inflight_pc = pc, pc += 4, go to WAIT.
  - WAIT: no request. On imem_resp_valid, deliver {resp_data, inflight_pc} and go to FETCH.
  - DRAIN: a redirect occurred while WAIT. The next imem_resp_valid is discarded, then go to FETCH.
- Delivery:
  - If !IF_valid or !stall, the response loads IF/ID (IF_valid = 1).
  - Otherwise it goes to the skid buffer (skid_valid = 1).
  - When !stall and skid_valid, the skid entry moves to IF/ID and the skid empties.
- IF/ID advance:
  - stall = 0 with nothing to deliver: IF_valid <= 0 (bubble), IF_instruction <= NOP_INSTR.
  - stall = 1: IF/ID holds all fields.
- Redirect (priority over stall and responses):
  - pc <= redirect_target, IF_valid <= 0, skid cleared.
  - IF_misaligned <= |redirect_target[1:0].
  - State: WAIT goes to DRAIN; FETCH stays FETCH, with no request issued this cycle; DRAIN stays DRAIN.
- Redirect in the same cycle as a response in WAIT: the response is discarded and state goes to FETCH, not DRAIN.
- Redirect while IF_misaligned = 1: IF_misaligned is recomputed from the new target. Fetch still proceeds at the aligned-down address {target[XLEN-1:2], 2'b00}.
- Latency:
  - Request accepted in cycle N, response in N+k (k≥1): IF_valid is visible in N+k+1.
  - Maximum throughput is 1 instruction per 2 cycles with k=1. There is no combinational resp→req path.
- PC wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 = 0).
- Skid full: no new request issues, so IF/ID plus skid cap at 2 instructions. No response is ever dropped except in DRAIN.
- Reset mid-WAIT: state goes to FETCH immediately. A late response arriving after reset while in FETCH is ignored.

Decomposition:
- riscv.h holds NOP_INSTR (32'h0000_0013), the default RESET_PC, and the fetch-state encodings (FETCH = 2'd0, WAIT = 2'd1, DRAIN = 2'd2) next to XLEN.
- One natural sub-module: fetch_skid_buffer, a 1-entry {instruction, pc} holding register with load/unload/clear.
- The FSM, PC and IF/ID register stay in instruction_fetch.

Test Plan:
- Reset release, ready = 1, responses 1 cycle later → requests at 0x0, 0x4, 0x8 on alternate cycles. IF_pc 0x0/0x4/0x8 with IF_valid = 1 carrying the returned words in order.
- stall = 1 for 5 cycles while streaming → IF/ID holds pc 0x4, the skid takes 0x8, no request issues while the skid is full. On release, 0x8 appears the next cycle and fetch resumes at 0xC.
- Redirect to 0x100 while WAIT for pc 0x10 → the response for 0x10 is discarded (never IF_valid). The next request is 0x100, and IF_pc = 0x100 is the next valid.
- Redirect to 0x200 coincident with stall = 1 and skid full → IF_valid = 0 and skid empty the next cycle, then fetch resumes at 0x200.
- Redirect to 0x102 → IF_misaligned = 1, fetch at 0x100. A later redirect to 0x300 clears it.
- pc = 0xFFFF_FFFC fetched → next request address is 0x0000_0000. Reset asserted mid-WAIT → IF_valid = 0, the next request goes to RESET_PC, and the stale response is ignored.
